// File: rtl/hamming_router_pkg.sv
// Shared definitions for the Hamming serial router.
//   - state_t        : serialiser FSM encoding (IDLE / SEND)
//   - CW_LEN, POS_*  : codeword length and on-wire bit order (index 0 goes first)
//   - parity3/7      : XOR helpers used for the Hamming and overall parity bits
package hamming_router_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int CW_LEN = 7;

  // Transmission order: p1, p2, d0, p4, d1, d2, d3, then p0 when SECDED is on.
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_P0 = 7;

  function automatic logic parity3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic parity7(input logic [CW_LEN-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/hamming_serial_router_if.sv
// Bus bundle between a nibble producer and the Hamming serial router.
//   in_valid/in_ready/in_sel/in_data : nibble offer handshake and destination channel
//   strobe                           : serialisation advance enable
//   d_out/d_valid                    : per-channel serial bit and its valid marker
//   d_first/d_last                   : first / last bit of the frame
//   busy                             : router is sending a frame
// master = producer/consumer side, slave = router side.
interface hamming_serial_router_if #(
  parameter int N_CH = 4
);
  localparam int SEL_W = $clog2(N_CH);

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [3:0]       in_data;
  logic             strobe;
  logic [N_CH-1:0]  d_out;
  logic [N_CH-1:0]  d_valid;
  logic             d_first;
  logic             d_last;
  logic             busy;

  modport master (
    output in_valid, in_sel, in_data, strobe,
    input  in_ready, d_out, d_valid, d_first, d_last, busy
  );

  modport slave (
    input  in_valid, in_sel, in_data, strobe,
    output in_ready, d_out, d_valid, d_first, d_last, busy
  );

endinterface

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder.
//   data     : 4-bit payload, data[0] = d0 ... data[3] = d3
//   codeword : 7-bit codeword laid out in transmission order (bit 0 goes first)
module hamming74_enc
  import hamming_router_pkg::*;
(
  input  logic [3:0]        data,
  output logic [CW_LEN-1:0] codeword
);

  always_comb begin
    codeword         = '0;
    codeword[POS_P1] = parity3(data[0], data[1], data[3]);
    codeword[POS_P2] = parity3(data[0], data[2], data[3]);
    codeword[POS_D0] = data[0];
    codeword[POS_P4] = parity3(data[1], data[2], data[3]);
    codeword[POS_D1] = data[1];
    codeword[POS_D2] = data[2];
    codeword[POS_D3] = data[3];
  end

endmodule

// File: rtl/hamming_serial_router.sv
// Hamming serial router: accepts a nibble plus a channel index, encodes it as a
// Hamming(7,4) codeword (optionally extended with an overall parity bit) and
// shifts it out one bit per strobe on the selected channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hamming_serial_router_if (handshake, strobe,
//                per-channel serial outputs, frame markers, busy)
module hamming_serial_router
  import hamming_router_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int SECDED = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hamming_serial_router_if.slave  bus
);

  localparam int SEL_W     = $clog2(N_CH);
  localparam int FRAME_LEN = CW_LEN + SECDED;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d, frame_new;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [N_CH-1:0]      sel_onehot;
  logic [CW_LEN-1:0]    cw;
  logic                 at_last, ready, accept;

  logic [N_CH-1:0]      d_out_p1, d_out_d;
  logic [N_CH-1:0]      vld_p1, vld_d;
  logic                 first_p1, first_d;
  logic                 last_p1, last_d;

  hamming74_enc u_enc (
    .data     (bus.in_data),
    .codeword (cw)
  );

  if (SECDED != 0) begin : g_secded
    always_comb begin
      frame_new               = '0;
      frame_new[CW_LEN-1:0]   = cw;
      frame_new[POS_P0]       = parity7(cw);
    end
  end else begin : g_plain
    assign frame_new = cw;
  end

  assign sel_onehot = N_CH'(1) << sel_q;
  assign at_last    = (idx_q == LAST_IDX);
  // A new nibble may land on the edge that ships the last bit, so frames abut.
  assign ready      = (state_q == IDLE) || (bus.strobe && at_last);
  assign accept     = bus.in_valid && ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    sel_d   = sel_q;
    d_out_d = '0;
    vld_d   = '0;
    first_d = 1'b0;
    last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        if (bus.strobe) begin
          d_out_d = sel_onehot & {N_CH{frame_q[idx_q]}};
          vld_d   = sel_onehot;
          first_d = (idx_q == '0);
          last_d  = at_last;
          if (at_last) begin
            idx_d = '0;
            if (!accept) state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      frame_d = frame_new;
      sel_d   = bus.in_sel;
      idx_d   = '0;
    end
  end

  // Stage p1: control state and registered serial outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      d_out_p1 <= '0;
      vld_p1   <= '0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      d_out_p1 <= d_out_d;
      vld_p1   <= vld_d;
      first_p1 <= first_d;
      last_p1  <= last_d;
    end
  end

  // Captured frame and destination are only read while in SEND.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    sel_q   <= sel_d;
  end

  assign bus.in_ready = ready;
  assign bus.d_out    = d_out_p1;
  assign bus.d_valid  = vld_p1;
  assign bus.d_first  = first_p1;
  assign bus.d_last   = last_p1;
  assign bus.busy     = (state_q == SEND);

endmodule

// File: tb/tb_hamming_serial_router.sv
`timescale 1ns/1ps
module tb_hamming_serial_router;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // Instance A: 4 channels, 7-bit frames. Instance B: 8 channels, 8-bit frames.
  hamming_serial_router_if #(.N_CH(4)) bus_a ();
  hamming_serial_router_if #(.N_CH(8)) bus_b ();

  hamming_serial_router #(.N_CH(4), .SECDED(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  hamming_serial_router #(.N_CH(8), .SECDED(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic       t_valid  [2];
  logic [2:0] t_sel    [2];
  logic [3:0] t_data   [2];
  logic       t_strobe [2];

  assign bus_a.in_valid = t_valid[0];
  assign bus_a.in_sel   = t_sel[0][1:0];
  assign bus_a.in_data  = t_data[0];
  assign bus_a.strobe   = t_strobe[0];
  assign bus_b.in_valid = t_valid[1];
  assign bus_b.in_sel   = t_sel[1];
  assign bus_b.in_data  = t_data[1];
  assign bus_b.strobe   = t_strobe[1];

  logic [7:0] o_dout [2];
  logic [7:0] o_dvld [2];
  logic       o_first[2], o_last[2], o_busy[2], o_ready[2];
  assign o_dout[0]  = {4'b0, bus_a.d_out};
  assign o_dvld[0]  = {4'b0, bus_a.d_valid};
  assign o_first[0] = bus_a.d_first;
  assign o_last[0]  = bus_a.d_last;
  assign o_busy[0]  = bus_a.busy;
  assign o_ready[0] = bus_a.in_ready;
  assign o_dout[1]  = bus_b.d_out;
  assign o_dvld[1]  = bus_b.d_valid;
  assign o_first[1] = bus_b.d_first;
  assign o_last[1]  = bus_b.d_last;
  assign o_busy[1]  = bus_b.busy;
  assign o_ready[1] = bus_b.in_ready;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int flen(input int k);
    return (k == 0) ? 7 : 8;
  endfunction

  // Frame in wire order (bit i goes out i-th). Built from Hamming positions:
  // data at positions 3,5,6,7; parity at 2^j covers every position with bit j set.
  function automatic logic [7:0] model_frame(input logic [3:0] d, input bit secded);
    logic [7:0] pos;
    logic [7:0] f;
    pos = '0;
    pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
    for (int j = 0; j < 3; j++) begin
      logic p;
      p = 1'b0;
      for (int n = 1; n < 8; n++)
        if (((n >> j) & 1) == 1 && n != (1 << j)) p = p ^ pos[n];
      pos[1 << j] = p;
    end
    f = '0;
    for (int i = 0; i < 7; i++) f[i] = pos[i + 1];
    if (secded) f[7] = ^f[6:0];
    return f;
  endfunction

  // Behavioural model: the frame in flight is a bit vector plus a count of bits
  // still to ship; one bit leaves per strobe.
  logic [7:0] m_bits [2];
  int         m_sel  [2];
  int         m_rem  [2];
  int         m_sent [2];
  logic [7:0] e_dout [2];
  logic [7:0] e_dvld [2];
  logic       e_first[2], e_last[2];

  function automatic bit m_ready(input int k);
    return (m_rem[k] == 0) || (t_strobe[k] && m_rem[k] == 1);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_bits[k] = '0; m_sel[k] = 0; m_rem[k] = 0; m_sent[k] = 0;
      e_dout[k] = '0; e_dvld[k] = '0; e_first[k] = 1'b0; e_last[k] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_rem[k] = 0; m_sent[k] = 0;
          e_dout[k] = '0; e_dvld[k] = '0; e_first[k] = 1'b0; e_last[k] = 1'b0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
          bit acc;
          acc = t_valid[k] && m_ready(k);
          e_dout[k] = '0; e_dvld[k] = '0; e_first[k] = 1'b0; e_last[k] = 1'b0;
          if (m_rem[k] > 0 && t_strobe[k]) begin
            e_dvld[k]  = 8'(1) << m_sel[k];
            e_dout[k]  = m_bits[k][m_sent[k]] ? e_dvld[k] : 8'h00;
            e_first[k] = (m_sent[k] == 0);
            e_last[k]  = (m_rem[k] == 1);
            m_sent[k]++;
            m_rem[k]--;
          end
          if (acc) begin
            m_bits[k] = model_frame(t_data[k], k == 1);
            m_sel[k]  = (k == 0) ? int'(t_sel[k][1:0]) : int'(t_sel[k]);
            m_rem[k]  = flen(k);
            m_sent[k] = 0;
          end
        end
      end
    end
  end

  // Bit log of every valid serial bit, for frame-level checks.
  logic       rec_bit [2][4096];
  int         rec_cyc [2][4096];
  logic [7:0] rec_dv  [2][4096];
  int         tot     [2];

  initial begin
    tot[0] = 0; tot[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, "_d_out"},    o_dout[k],  e_dout[k]);
        chk({p, "_d_valid"},  o_dvld[k],  e_dvld[k]);
        chk({p, "_d_first"},  o_first[k], e_first[k]);
        chk({p, "_d_last"},   o_last[k],  e_last[k]);
        chk({p, "_busy"},     o_busy[k],  m_rem[k] > 0);
        chk({p, "_in_ready"}, o_ready[k], m_ready(k));
        if (o_dvld[k] != 0 && tot[k] < 4096) begin
          rec_bit[k][tot[k]] = |o_dout[k];
          rec_cyc[k][tot[k]] = cyc;
          rec_dv[k][tot[k]]  = o_dvld[k];
          tot[k]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [2:0] sel, input logic [3:0] data, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    t_valid[k] = 1'b1; t_sel[k] = sel; t_data[k] = data;
    for (int i = 0; i < 60 && !done; i++) begin
      if (m_ready(k)) begin
        step();
        acc_cyc = cyc;
        done = 1'b1;
      end else begin
        step();
      end
    end
    chk("send_accepted", done, 1'b1);
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 100 && m_rem[k] != 0; i++) step();
    step();
    chk("idle_model", m_rem[k], 0);
    chk("idle_busy", o_busy[k], 1'b0);
  endtask

  task automatic chk_frame(input int k, input int s, input int n, input logic [15:0] exp,
                           input int span, input string nm);
    logic [15:0] got;
    got = '0;
    chk({nm, "_count"}, tot[k] - s, n);
    for (int i = 0; i < n; i++) got[i] = rec_bit[k][s + i];
    chk({nm, "_bits"}, got, exp);
    chk({nm, "_span"}, rec_cyc[k][s + n - 1] - rec_cyc[k][s] + 1, span);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, ac;
    for (int k = 0; k < 2; k++) begin
      t_valid[k] = 1'b0; t_sel[k] = '0; t_data[k] = '0; t_strobe[k] = 1'b1;
    end

    // Hand-computed codewords pin the model.
    chk("model_1011",  model_frame(4'b1011, 1'b0), 8'h55);
    chk("model_1111s", model_frame(4'b1111, 1'b1), 8'hFF);
    chk("model_0110s", model_frame(4'b0110, 1'b1), 8'h33);
    chk("model_0000",  model_frame(4'b0000, 1'b0), 8'h00);

    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Single frames: A ch2 1011 (7 bits), B ch0 1111 (8 bits), accepted on first edge.
    s0 = tot[0]; s1 = tot[1];
    t_valid[0] = 1'b1; t_sel[0] = 3'd2; t_data[0] = 4'b1011;
    t_valid[1] = 1'b1; t_sel[1] = 3'd0; t_data[1] = 4'b1111;
    step();
    ac = cyc;
    chk("first_accept_A", o_busy[0], 1'b1);
    chk("first_accept_B", o_busy[1], 1'b1);
    t_valid[0] = 1'b0; t_valid[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    chk_frame(0, s0, 7, 16'h0055, 7, "A_single");
    chk("A_latency", rec_cyc[0][s0], ac + 1);
    chk("A_dvalid", rec_dv[0][s0], 8'h04);
    chk_frame(1, s1, 8, 16'h00FF, 8, "B_secded");
    chk("B_dvalid", rec_dv[1][s1], 8'h01);

    // Strobe toggling stretches the frame to 13 cycles.
    s0 = tot[0];
    send(0, 3'd2, 4'b1011, ac);
    t_valid[0] = 1'b0;
    for (int i = 0; i < 40 && m_rem[0] != 0; i++) begin
      t_strobe[0] = (i % 2 == 0);
      step();
    end
    t_strobe[0] = 1'b1;
    wait_idle(0);
    chk_frame(0, s0, 7, 16'h0055, 13, "A_stall");

    // Back-to-back frames with in_valid held: ch1 1011 then ch3 0000.
    s0 = tot[0];
    send(0, 3'd1, 4'b1011, ac);
    send(0, 3'd3, 4'b0000, ac);
    t_valid[0] = 1'b0;
    wait_idle(0);
    chk_frame(0, s0, 14, 16'h0055, 14, "A_b2b");
    chk("A_b2b_dv_first", rec_dv[0][s0], 8'h02);
    chk("A_b2b_dv_switch", rec_dv[0][s0 + 7], 8'h08);
    chk("A_b2b_dv_last", rec_dv[0][s0 + 13], 8'h08);

    // Reset mid-frame after four bits, then a full fresh frame.
    s0 = tot[0];
    send(0, 3'd2, 4'b1011, ac);
    t_valid[0] = 1'b0;
    for (int i = 0; i < 20 && (tot[0] - s0) < 4; i++) step();
    rst_n = 1'b0;
    #1;
    chk("rst_d_out", o_dout[0], 8'h00);
    chk("rst_d_valid", o_dvld[0], 8'h00);
    chk("rst_busy", o_busy[0], 1'b0);
    chk("rst_ready", o_ready[0], 1'b1);
    step();
    rst_n = 1'b1;
    chk("rst_aborted_bits", tot[0] - s0, 4);
    s0 = tot[0];
    send(0, 3'd2, 4'b1011, ac);
    t_valid[0] = 1'b0;
    wait_idle(0);
    chk_frame(0, s0, 7, 16'h0055, 7, "A_after_rst");

    // B ch7 0110 with in_data scrambled during the frame.
    s1 = tot[1];
    send(1, 3'd7, 4'b0110, ac);
    t_valid[1] = 1'b0;
    for (int i = 0; i < 40 && m_rem[1] != 0; i++) begin
      t_data[1] = 4'($urandom);
      t_sel[1] = 3'($urandom);
      step();
    end
    wait_idle(1);
    chk_frame(1, s1, 8, 16'h0033, 8, "B_hold");
    chk("B_hold_dvalid", rec_dv[1][s1], 8'h80);

    // Random traffic on both instances, with one reset pulse midway.
    for (int i = 0; i < 600; i++) begin
      t_valid[0]  = 1'($urandom % 2);
      t_sel[0]    = 3'($urandom_range(0, 3));
      t_data[0]   = 4'($urandom);
      t_strobe[0] = ($urandom % 4) != 0;
      t_valid[1]  = 1'($urandom % 2);
      t_sel[1]    = 3'($urandom_range(0, 7));
      t_data[1]   = 4'($urandom);
      t_strobe[1] = ($urandom % 4) != 0;
      if (i == 300) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    for (int k = 0; k < 2; k++) begin
      t_valid[k] = 1'b0;
      t_strobe[k] = 1'b1;
    end
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
